// File: rtl/pe_instr_sequencer.sv
// pe_instr_sequencer
//   Fetches a contiguous program for one PE from instruction memory and feeds it to the
//   functional unit over an instr/instr_req/instr_ack handshake. A small prefetch FIFO with
//   credit-based read issue keeps one instruction per cycle flowing while acks continue.
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i                 launch program (ignored while busy)
//   start_addr_i            first instruction address, sampled on accepted start
//   instr_cnt_i             program length, sampled on accepted start
//   busy_o, done_o          program in progress / 1-cycle retire-complete pulse
//   stall_cycles_o          cycles with instr_req_o=1 and instr_ack_i=0 since last start
//   imem_rd_en_o/addr_o     instruction memory read request
//   imem_rd_data_i          read data, valid one cycle after imem_rd_en_o
//   instr_o, instr_req_o    head-of-FIFO instruction and its valid
//   instr_ack_i             functional unit retired the presented instruction
module pe_instr_sequencer #(
  parameter int unsigned INSTR_W     = 32,
  parameter int unsigned IMEM_ADDR_W = 12,
  parameter int unsigned FIFO_DEPTH  = 2,
  parameter int unsigned CNT_W       = 13
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic [IMEM_ADDR_W-1:0] start_addr_i,
  input  logic [CNT_W-1:0]       instr_cnt_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [31:0]            stall_cycles_o,
  output logic                   imem_rd_en_o,
  output logic [IMEM_ADDR_W-1:0] imem_rd_addr_o,
  input  logic [INSTR_W-1:0]     imem_rd_data_i,
  output logic [INSTR_W-1:0]     instr_o,
  output logic                   instr_req_o,
  input  logic                   instr_ack_i
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OccW = PtrW + 1;
  localparam logic [OccW:0] DepthC = (OccW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e                 state_q, state_d;
  logic [IMEM_ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0]       issued_q, issued_d;
  logic [CNT_W-1:0]       retired_q, retired_d;
  logic [31:0]            stall_q, stall_d;
  logic                   done_q, done_d;
  logic                   inflight_q;
  logic [INSTR_W-1:0]     fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [OccW-1:0]        occ_q, occ_d;

  logic                   push, pop;
  logic [OccW:0]          credit_used, credit_avail;

  // Data for the read issued last cycle lands this cycle; reset clears inflight_q, so a
  // read launched before reset is never pushed.
  assign push        = inflight_q;
  assign instr_req_o = (occ_q != '0);
  assign pop         = instr_req_o & instr_ack_i;

  // Credit check written as occ + inflight < depth + pop to avoid an unsigned underflow.
  assign credit_used  = {1'b0, occ_q} + {{OccW{1'b0}}, inflight_q};
  assign credit_avail = DepthC + {{OccW{1'b0}}, pop};

  assign imem_rd_en_o   = (state_q == StFetch) && (credit_used < credit_avail);
  assign imem_rd_addr_o = addr_q + issued_q[IMEM_ADDR_W-1:0];
  assign instr_o        = instr_req_o ? fifo_q[rd_ptr_q] : '0;
  assign busy_o         = (state_q != StIdle);
  assign done_o         = done_q;
  assign stall_cycles_o = stall_q;

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    issued_d  = issued_q;
    retired_d = retired_q;
    stall_d   = stall_q;
    done_d    = 1'b0;

    if (instr_req_o && !instr_ack_i && (stall_q != '1)) stall_d = stall_q + 32'd1;
    if (imem_rd_en_o) issued_d = issued_q + CNT_W'(1);
    if (pop) retired_d = retired_q + CNT_W'(1);

    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          stall_d = '0;
          if (instr_cnt_i != '0) begin
            state_d   = StFetch;
            addr_d    = start_addr_i;
            cnt_d     = instr_cnt_i;
            issued_d  = '0;
            retired_d = '0;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StFetch: begin
        if (imem_rd_en_o && (issued_q == cnt_q - CNT_W'(1))) state_d = StDrain;
      end
      StDrain: begin
        if (pop && (retired_q == cnt_q - CNT_W'(1))) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    occ_d = occ_q;
    unique case ({push, pop})
      2'b10:   occ_d = occ_q + OccW'(1);
      2'b01:   occ_d = occ_q - OccW'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      cnt_q      <= '0;
      issued_q   <= '0;
      retired_q  <= '0;
      stall_q    <= '0;
      done_q     <= 1'b0;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      issued_q   <= issued_d;
      retired_q  <= retired_d;
      stall_q    <= stall_d;
      done_q     <= done_d;
      inflight_q <= imem_rd_en_o;
      occ_q      <= occ_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

  // Storage needs no reset: instr_o is masked whenever the FIFO is empty.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= imem_rd_data_i;
  end

endmodule

// File: tb/tb_pe_instr_sequencer.sv
module tb_pe_instr_sequencer;

  logic        clk;
  logic        rst_i;
  logic        start_i;
  logic [11:0] start_addr_i;
  logic [12:0] instr_cnt_i;
  logic        busy_o, done_o;
  logic [31:0] stall_cycles_o;
  logic        imem_rd_en_o;
  logic [11:0] imem_rd_addr_o;
  logic [31:0] imem_rd_data_i;
  logic [31:0] instr_o;
  logic        instr_req_o;
  logic        instr_ack_i;

  pe_instr_sequencer dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .start_addr_i   (start_addr_i),
    .instr_cnt_i    (instr_cnt_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .stall_cycles_o (stall_cycles_o),
    .imem_rd_en_o   (imem_rd_en_o),
    .imem_rd_addr_o (imem_rd_addr_o),
    .imem_rd_data_i (imem_rd_data_i),
    .instr_o        (instr_o),
    .instr_req_o    (instr_req_o),
    .instr_ack_i    (instr_ack_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_val(input logic [11:0] a);
    return {a, 8'h5A, ~a};
  endfunction

  // One-cycle-latency instruction memory model
  always @(posedge clk) begin
    if (imem_rd_en_o) imem_rd_data_i <= mem_val(imem_rd_addr_o);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: unexpected event (cycle %0d)", name, cyc);
  endtask

  // Scoreboard
  logic [11:0] exp_addr_q [$];
  logic [31:0] exp_data_q [$];
  int          first_rd, first_req, rd_cnt, done_cnt;
  bit          prev_stall;
  logic [31:0] prev_instr;

  always @(negedge clk) begin
    if (!rst_i) begin
      if (imem_rd_en_o) begin
        rd_cnt++;
        if (first_rd < 0) first_rd = cyc;
        if (exp_addr_q.size() == 0) fail_now("rd_addr_extra");
        else check("rd_addr", {20'd0, imem_rd_addr_o}, {20'd0, exp_addr_q.pop_front()});
      end
      if (instr_req_o && first_req < 0) first_req = cyc;
      if (instr_req_o && prev_stall) check("instr_stable", instr_o, prev_instr);
      if (instr_req_o && instr_ack_i) begin
        if (exp_data_q.size() == 0) fail_now("instr_extra");
        else check("instr_data", instr_o, exp_data_q.pop_front());
      end
      prev_stall = instr_req_o && !instr_ack_i;
      prev_instr = instr_o;
      if (done_o) begin
        done_cnt++;
        check("done_busy_overlap", {31'd0, busy_o}, 32'd0);
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  typedef struct {
    logic [11:0] addr;
    logic [12:0] cnt;
    int          stall;
    logic [31:0] exp_stall;
    int          exp_done_lat;
    int          exp_rd;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input bit pulse_mid, input string tag);
    int  t0, lat, stall_left, busy_cnt;
    bit  seen;
    first_rd = -1; first_req = -1; rd_cnt = 0; done_cnt = 0;
    busy_cnt = 0; seen = 0; lat = 0; stall_left = v.stall;
    for (int i = 0; i < int'(v.cnt); i++) begin
      exp_addr_q.push_back(v.addr + 12'(i));
      exp_data_q.push_back(mem_val(v.addr + 12'(i)));
    end
    @(posedge clk); #1;
    start_i = 1'b1; start_addr_i = v.addr; instr_cnt_i = v.cnt; instr_ack_i = 1'b1;
    t0 = cyc;
    for (int k = 1; k <= 200; k++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (pulse_mid && k == 2) begin
        start_i = 1'b1; start_addr_i = 12'h100; instr_cnt_i = 13'd7;
      end
      if (instr_req_o && stall_left > 0) begin
        instr_ack_i = 1'b0;
        stall_left--;
      end else begin
        instr_ack_i = 1'b1;
      end
      @(negedge clk);
      if (busy_o) busy_cnt++;
      if (done_o) begin
        lat = cyc - t0;
        seen = 1;
        break;
      end
    end
    if (!seen) fail_now({tag, "_done_timeout"});
    check({tag, "_done_lat"}, lat, v.exp_done_lat);
    check({tag, "_stall"}, stall_cycles_o, v.exp_stall);
    check({tag, "_rd_cnt"}, rd_cnt, v.exp_rd);
    check({tag, "_busy_cycles"}, busy_cnt, (v.cnt != 0) ? v.exp_done_lat - 1 : 0);
    if (v.cnt != 0) begin
      check({tag, "_rd_lat"}, first_rd - t0, 1);
      check({tag, "_req_lat"}, first_req - t0, 3);
    end
    check({tag, "_addr_left"}, exp_addr_q.size(), 0);
    check({tag, "_data_left"}, exp_data_q.size(), 0);
    start_i = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_done_pulse"}, {31'd0, done_o}, 32'd0);
    check({tag, "_stall_hold"}, stall_cycles_o, v.exp_stall);
    check({tag, "_done_count"}, done_cnt, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_busy"}, {31'd0, busy_o}, 32'd0);
    check({tag, "_done"}, {31'd0, done_o}, 32'd0);
    check({tag, "_stall"}, stall_cycles_o, 32'd0);
    check({tag, "_rd_en"}, {31'd0, imem_rd_en_o}, 32'd0);
    check({tag, "_rd_addr"}, {20'd0, imem_rd_addr_o}, 32'd0);
    check({tag, "_instr"}, instr_o, 32'd0);
    check({tag, "_req"}, {31'd0, instr_req_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{addr: 12'h010, cnt: 13'd4, stall: 0, exp_stall: 32'd0, exp_done_lat: 7,  exp_rd: 4};
    vecs[1] = '{addr: 12'h200, cnt: 13'd3, stall: 5, exp_stall: 32'd5, exp_done_lat: 11, exp_rd: 3};
    vecs[2] = '{addr: 12'hFFE, cnt: 13'd4, stall: 0, exp_stall: 32'd0, exp_done_lat: 7,  exp_rd: 4};
    vecs[3] = '{addr: 12'h7F0, cnt: 13'd6, stall: 2, exp_stall: 32'd2, exp_done_lat: 11, exp_rd: 6};
    vecs[4] = '{addr: 12'h020, cnt: 13'd1, stall: 0, exp_stall: 32'd0, exp_done_lat: 4,  exp_rd: 1};
    vecs[5] = '{addr: 12'h000, cnt: 13'd0, stall: 0, exp_stall: 32'd0, exp_done_lat: 1,  exp_rd: 0};

    rst_i = 1'b1; start_i = 1'b0; start_addr_i = '0; instr_cnt_i = '0; instr_ack_i = 1'b0;
    first_rd = -1; first_req = -1; rd_cnt = 0; done_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs_zero("reset");
    @(posedge clk); #1;
    rst_i = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(vecs[i], 1'b0, $sformatf("vec%0d", i));

    // Start pulsed mid-program must be ignored
    run_vec('{addr: 12'h040, cnt: 13'd5, stall: 0, exp_stall: 32'd0, exp_done_lat: 8,
              exp_rd: 5}, 1'b1, "busy_start");

    // Reset with the FIFO partly filled and a read in flight
    for (int i = 0; i < 6; i++) begin
      exp_addr_q.push_back(12'h300 + 12'(i));
      exp_data_q.push_back(mem_val(12'h300 + 12'(i)));
    end
    first_rd = -1; first_req = -1; rd_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    start_i = 1'b1; start_addr_i = 12'h300; instr_cnt_i = 13'd6; instr_ack_i = 1'b0;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    check("pre_reset_req", {31'd0, instr_req_o}, 32'd1);
    rst_i = 1'b1;
    #1;
    check_outputs_zero("midrst");
    @(posedge clk); #1;
    rst_i = 1'b0;
    instr_ack_i = 1'b1;
    exp_addr_q.delete();
    exp_data_q.delete();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_rst_req", {31'd0, instr_req_o}, 32'd0);
      check("post_rst_done", {31'd0, done_o}, 32'd0);
      check("post_rst_busy", {31'd0, busy_o}, 32'd0);
    end
    check("post_rst_done_cnt", done_cnt, 0);

    run_vec(vecs[0], 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
